leg_solver: RTL and testbench

LEG_SOLVER -- requirements
Module: leg_solver

---
 rtl/leg_solver.sv | 155 +++++++++++++++
 tb/tb_leg_solver.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/leg_solver.sv
// Computes floor(sqrt(r^2 - x^2)) for unsigned operands. It squares the inputs with
// shift-and-add, then runs a restoring square root.
module leg_solver #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic         start,
    input  logic [W-1:0] r_in,
    input  logic [W-1:0] x_in,
    output logic [W-1:0] y_out,
    output logic         valid,
    output logic         busy,
    output logic         err
);
    localparam int CW = $clog2(W) + 1;
    localparam logic [2*W-1:0] ZERO2 = {(2*W){1'b0}};
    localparam logic [2*W-1:0] BIT_INIT = {{(2*W-1){1'b0}}, 1'b1} << (2*W-2);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SQR  = 3'd1,
        SUB  = 3'd2,
        ROOT = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t          state_r, state_s;
    logic [W-1:0]    r_r, x_r;
    logic [2*W-1:0]  acc_r_r, acc_x_r;
    logic [2*W-1:0]  rem_r, res_r, bit_r;
    logic [CW-1:0]   cnt_r;
    logic [W-1:0]    y_r;
    logic            err_r;

    logic [2*W-1:0]  add_r_s, add_x_s;
    logic            lt_s;
    logic [2*W-1:0]  trial_s, rem_s, res_s;
    logic [CW-2:0]   idx_s;

    // Next-state decode; the counter gives SQR one trailing cycle so latency is fixed.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_s = SQR;
                else       state_s = IDLE;
            end
            SQR: begin
                if (cnt_r == CW'(W)) state_s = SUB;
                else                 state_s = SQR;
            end
            SUB: begin
                if (lt_s) state_s = DONE;
                else      state_s = ROOT;
            end
            ROOT: begin
                if (cnt_r == CW'(W-1)) state_s = DONE;
                else                   state_s = ROOT;
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Shift-and-add partial products and one restoring-root digit step.
    always_comb begin
        idx_s   = cnt_r[CW-2:0];
        add_r_s = ZERO2;
        add_x_s = ZERO2;
        if ((cnt_r < CW'(W)) && r_r[idx_s]) add_r_s = {{W{1'b0}}, r_r} << cnt_r;
        else                                add_r_s = ZERO2;
        if ((cnt_r < CW'(W)) && x_r[idx_s]) add_x_s = {{W{1'b0}}, x_r} << cnt_r;
        else                                add_x_s = ZERO2;
        lt_s    = (acc_r_r < acc_x_r);
        trial_s = res_r | bit_r;
        if (rem_r >= trial_s) begin
            rem_s = rem_r - trial_s;
            res_s = (res_r >> 1) | bit_r;
        end else begin
            rem_s = rem_r;
            res_s = res_r >> 1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   state_r <= IDLE;
        else if (ena) state_r <= state_s;
    end

    // Datapath registers; everything holds while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r     <= {W{1'b0}};
            x_r     <= {W{1'b0}};
            acc_r_r <= ZERO2;
            acc_x_r <= ZERO2;
            rem_r   <= ZERO2;
            res_r   <= ZERO2;
            bit_r   <= ZERO2;
            cnt_r   <= {CW{1'b0}};
            y_r     <= {W{1'b0}};
            err_r   <= 1'b0;
        end else if (ena) begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        r_r     <= r_in;
                        x_r     <= x_in;
                        acc_r_r <= ZERO2;
                        acc_x_r <= ZERO2;
                        cnt_r   <= {CW{1'b0}};
                    end
                end
                SQR: begin
                    if (cnt_r < CW'(W)) begin
                        acc_r_r <= acc_r_r + add_r_s;
                        acc_x_r <= acc_x_r + add_x_s;
                        cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                SUB: begin
                    if (lt_s) begin
                        y_r   <= {W{1'b0}};
                        err_r <= 1'b1;
                    end else begin
                        rem_r <= acc_r_r - acc_x_r;
                        res_r <= ZERO2;
                        bit_r <= BIT_INIT;
                        cnt_r <= {CW{1'b0}};
                    end
                end
                ROOT: begin
                    rem_r <= rem_s;
                    res_r <= res_s;
                    bit_r <= bit_r >> 2;
                    cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_r == CW'(W-1)) begin
                        y_r   <= res_s[W-1:0];
                        err_r <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign y_out = y_r;
    assign err   = err_r;
    assign valid = (state_r == DONE);
    assign busy  = (state_r != IDLE);

endmodule

// File: tb/tb_leg_solver.sv
// Directed bench for leg_solver. Expected results come from an integer model and
// are queued at launch, then popped and compared when valid is seen.
module tb_leg_solver;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       start = 1'b0;
    logic [7:0] r_in = 8'd0;
    logic [7:0] x_in = 8'd0;
    logic [7:0] y_out;
    logic       valid, busy, err;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] y;
        logic       e;
        int         lat;
    } exp_t;
    exp_t sb[$];

    leg_solver #(.W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
        .r_in(r_in), .x_in(x_in), .y_out(y_out),
        .valid(valid), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(int r, int x);
        exp_t m;
        int d, y;
        if (x > r) begin
            m.y = 8'd0; m.e = 1'b1; m.lat = 10;
        end else begin
            d = r * r - x * x;
            y = 0;
            while ((y + 1) * (y + 1) <= d) y++;
            m.y = 8'(y); m.e = 1'b0; m.lat = 18;
        end
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic launch(input int r, input int x, input bit push);
        @(negedge clk);
        r_in = 8'(r); x_in = 8'(x); start = 1'b1;
        if (push) sb.push_back(model(r, x));
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // drop_at: edge after which ena goes low for 5 edges; repulse: re-pulse start
    // mid-flight; hold: raise start while in DONE for a follow-up r=8,x=0 run.
    task automatic collect(input string tag, input int drop_at, input bit repulse, input bit hold);
        exp_t e;
        int   lat_seen;
        bit   got, busy_ok;
        logic [7:0] y_keep;
        e = sb.pop_front();
        got = 1'b0; busy_ok = 1'b1; lat_seen = 0;
        for (int i = 1; i <= 80 && !got; i++) begin
            @(posedge clk); #1;
            if (valid) begin
                got = 1'b1;
                lat_seen = i;
                if (hold) begin
                    start = 1'b1; r_in = 8'd8; x_in = 8'd0;
                    sb.push_back(model(8, 0));
                end
            end else begin
                if (!busy) busy_ok = 1'b0;
                if (drop_at > 0 && i == drop_at) ena = 1'b0;
                if (drop_at > 0 && i == drop_at + 5) ena = 1'b1;
                if (repulse) begin
                    if (i == 3 || i == 13) begin
                        start = 1'b1; r_in = 8'd13; x_in = 8'd5;
                    end else begin
                        start = 1'b0;
                    end
                end
            end
        end
        check({tag, "_valid_seen"}, 32'(got), 32'd1);
        check({tag, "_latency"}, 32'(lat_seen), 32'(e.lat + ((drop_at > 0) ? 5 : 0)));
        check({tag, "_busy"}, 32'(busy_ok), 32'd1);
        check({tag, "_y"}, 32'(y_out), 32'(e.y));
        check({tag, "_err"}, 32'(err), 32'(e.e));
        y_keep = y_out;
        @(posedge clk); #1;
        check({tag, "_valid_one_cycle"}, 32'(valid), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_y_hold"}, 32'(y_out), 32'(y_keep));
    endtask

    initial begin
        int vcount;
        #1;
        check("rst_y", 32'(y_out), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        launch(5, 3, 1'b1);   collect("r5x3", 0, 1'b0, 1'b0);
        launch(255, 0, 1'b1); collect("r255x0", 0, 1'b0, 1'b0);
        launch(10, 10, 1'b1); collect("r10x10", 0, 1'b0, 1'b0);
        launch(10, 1, 1'b1);  collect("r10x1", 0, 1'b0, 1'b0);
        launch(3, 4, 1'b1);   collect("r3x4_err", 0, 1'b0, 1'b0);

        launch(5, 3, 1'b1);   collect("repulse_ignored", 0, 1'b1, 1'b0);
        launch(13, 5, 1'b1);  collect("r13x5", 0, 1'b0, 1'b0);

        launch(10, 6, 1'b1);  collect("ena_drop", 12, 1'b0, 1'b0);

        // start held through DONE is only taken on the following IDLE cycle
        launch(7, 7, 1'b1);   collect("done_start", 0, 1'b0, 1'b1);
        @(posedge clk); #1;
        start = 1'b0;
        check("held_start_accepted", 32'(busy), 32'd1);
        collect("r8x0_after_hold", 0, 1'b0, 1'b0);

        // reset mid-SQR aborts without valid
        launch(5, 3, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_y", 32'(y_out), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        vcount = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (valid || busy) vcount++;
        end
        check("midrst_no_activity", 32'(vcount), 32'd0);
        launch(5, 4, 1'b1);   collect("r5x4_after_rst", 0, 1'b0, 1'b0);

        for (int k = 0; k < 4; k++) begin
            int rr, xx;
            rr = int'($urandom_range(255, 0));
            xx = int'($urandom_range(255, 0));
            launch(rr, xx, 1'b1);
            collect($sformatf("rand%0d_r%0d_x%0d", k, rr, xx), 0, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
